serial_frame_deserializer: RTL

Receive-side counterpart to the team's universal shift register. It accepts a framed serial bitstream one bit per qualified clock and assembles WIDTH-bit words. Each frame can arrive MSB-first (left-shift) or LSB-first (right-shift). Completed words are handed off through a single-entry output buffer with a valid/ready handshake, and the block flags overrun and frame abort.

---
 rtl/serial_frame_deserializer_if.sv | 30 +++
 rtl/serial_frame_deserializer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/serial_frame_deserializer_if.sv
// Handshake and serial-input bundle for serial_frame_deserializer.
// The slave modport is the deserializer side, and the master modport is the producer/consumer side.
interface serial_frame_deserializer_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             frame_start;
    logic             dir;
    logic             sdata;
    logic             sdata_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [CNT_W-1:0] bit_count;
    logic             overrun;
    logic             clr_overrun;
    logic             frame_abort;

    modport slave (
        input  frame_start, dir, sdata, sdata_valid, out_ready, clr_overrun,
        output out_data, out_valid, busy, bit_count, overrun, frame_abort
    );

    modport master (
        output frame_start, dir, sdata, sdata_valid, out_ready, clr_overrun,
        input  out_data, out_valid, busy, bit_count, overrun, frame_abort
    );
endinterface

// File: rtl/serial_frame_deserializer.sv
// Framed serial-to-parallel receiver with MSB/LSB-first shifting, a single-entry
// valid/ready output buffer, a sticky overrun flag and a frame-abort pulse.
module serial_frame_deserializer #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_frame_deserializer_if.slave  bus
);
    typedef enum logic {IDLE, RECV} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
    logic             abort_q, abort_d;

    logic             complete;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] start_sreg;
    logic [CNT_W-1:0] start_cnt;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s,
                                                  input logic b,
                                                  input logic lsb_first);
        return lsb_first ? {b, s[WIDTH-1:1]} : {s[WIDTH-2:0], b};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            sreg_q      <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            abort_q     <= abort_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        abort_d    = 1'b0;
        complete   = 1'b0;
        word       = shift_in(sreg_q, bus.sdata, dir_q);

        // A frame opening always starts from an empty register; a coincident
        // valid bit is already bit 1 of that frame.
        start_sreg = bus.sdata_valid ? shift_in('0, bus.sdata, bus.dir) : '0;
        start_cnt  = bus.sdata_valid ? CNT_W'(1) : '0;

        case (state_q)
            IDLE: begin
                if (bus.frame_start) begin
                    state_d = RECV;
                    dir_d   = bus.dir;
                    sreg_d  = start_sreg;
                    cnt_d   = start_cnt;
                end
            end
            RECV: begin
                if (bus.sdata_valid) begin
                    sreg_d = word;
                    if (cnt_q == LAST_IDX) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // A restart on the completion edge lets the word complete; the
                // same bit then also opens the next frame.
                if (bus.frame_start) begin
                    abort_d = ~complete;
                    state_d = RECV;
                    dir_d   = bus.dir;
                    sreg_d  = start_sreg;
                    cnt_d   = start_cnt;
                end
            end
            default: state_d = IDLE;
        endcase

        out_data_d  = out_data_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        overrun_d   = overrun_q & ~bus.clr_overrun;
        if (complete) begin
            if (!out_valid_q || bus.out_ready) begin
                out_data_d  = word;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        bus.out_data    = out_data_q;
        bus.out_valid   = out_valid_q;
        bus.busy        = (state_q == RECV);
        bus.bit_count   = cnt_q;
        bus.overrun     = overrun_q;
        bus.frame_abort = abort_q;
    end
endmodule
